// File: rtl/heaa_pkg.sv
// Shared definitions for the hybrid approximate adder error-measurement blocks.
package heaa_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  // |exact - approx| of two WIDTH+1-bit sums never exceeds 2^(WIDTH+1)-1.
  function automatic int ed_width(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/heaa_err_monitor_if.sv
// Sample stream and report stream of the error monitor, bundled for port reuse.
interface heaa_err_monitor_if #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 48,
  parameter int CNT_W = 11
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH:0]   in_approx;

  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_err_count;
  logic [ACC_W-1:0] rpt_ed_sum;
  logic [WIDTH:0]   rpt_ed_max;

  modport master (
    output in_valid, in_a, in_b, in_approx, rpt_ready,
    input  in_ready, rpt_valid, rpt_err_count, rpt_ed_sum, rpt_ed_max
  );

  modport slave (
    input  in_valid, in_a, in_b, in_approx, rpt_ready,
    output in_ready, rpt_valid, rpt_err_count, rpt_ed_sum, rpt_ed_max
  );

endinterface

// File: rtl/heaa_err_dist.sv
// Exact sum and error distance of one approximate-adder result; purely combinational.
module heaa_err_dist
  import heaa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx,
  output logic [WIDTH:0]   exact,
  output logic [WIDTH:0]   ed
);

  logic signed [WIDTH+1:0] diff;
  logic signed [WIDTH+1:0] diff_neg;

  always_comb begin
    exact    = {1'b0, a} + {1'b0, b};
    diff     = $signed({1'b0, exact}) - $signed({1'b0, approx});
    diff_neg = -diff;
    ed       = diff[WIDTH+1] ? diff_neg[WIDTH:0] : diff[WIDTH:0];
  end

endmodule

// File: rtl/heaa_err_monitor.sv
// Windowed error statistics (error count, saturating ED sum, max ED) for an approximate adder.
module heaa_err_monitor
  import heaa_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SAMPLES = 1024,
  parameter int ACC_W   = 48,
  parameter int CNT_W   = $clog2(SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  heaa_err_monitor_if.slave bus
);

  localparam int ED_W = ed_width(WIDTH);

  state_t           state;
  state_t           state_next;

  logic [CNT_W-1:0] accepted;
  logic             s1_valid;
  logic [ED_W-1:0]  s1_ed;
  logic [CNT_W-1:0] acc_count;
  logic [ACC_W-1:0] acc_sum;
  logic [ED_W-1:0]  acc_max;

  logic [ED_W-1:0]  ed;
  logic [ED_W-1:0]  unused_exact;
  logic             handshake;
  logic             last_acc;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_sat;

  heaa_err_dist #(.WIDTH(WIDTH)) u_err_dist (
    .a      (bus.in_a),
    .b      (bus.in_b),
    .approx (bus.in_approx),
    .exact  (unused_exact),
    .ed     (ed)
  );

  assign handshake = bus.in_valid && bus.in_ready;
  // Stage 1 holds the SAMPLES-th sample exactly when accepted has reached SAMPLES.
  assign last_acc  = s1_valid && (accepted == CNT_W'(SAMPLES));

  // Carry out of the widened add means overflow; an all-ones sum stays all-ones.
  always_comb begin
    sum_ext = {1'b0, acc_sum} + (ACC_W + 1)'(s1_ed);
    sum_sat = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (abort && state != IDLE) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start)         state_next = RUN;
        RUN:     if (last_acc)      state_next = REPORT;
        REPORT:  if (bus.rpt_ready) state_next = IDLE;
        default:                    state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state == RUN) && (accepted < CNT_W'(SAMPLES)) && !abort;
    bus.rpt_valid = (state == REPORT);
    busy          = (state != IDLE);
  end

  // NOTE: the datapath registers are reset too, because rpt_* must read 0 straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted  <= '0;
      s1_valid  <= 1'b0;
      s1_ed     <= '0;
      acc_count <= '0;
      acc_sum   <= '0;
      acc_max   <= '0;
    end else if (state == IDLE && start) begin
      accepted  <= '0;
      s1_valid  <= 1'b0;
      acc_count <= '0;
      acc_sum   <= '0;
      acc_max   <= '0;
    end else if (abort && state != IDLE) begin
      s1_valid  <= 1'b0;
    end else if (state == RUN) begin
      s1_valid <= handshake;
      if (handshake) begin
        s1_ed    <= ed;
        accepted <= accepted + CNT_W'(1);
      end
      if (s1_valid) begin
        acc_count <= acc_count + CNT_W'(s1_ed != '0);
        acc_sum   <= sum_sat;
        if (s1_ed > acc_max) acc_max <= s1_ed;
      end
    end
  end

  assign bus.rpt_err_count = acc_count;
  assign bus.rpt_ed_sum    = acc_sum;
  assign bus.rpt_ed_max    = acc_max;

endmodule

// File: tb/tb_heaa_err_monitor.sv
// Self-checking bench for heaa_err_monitor: directed windows plus randomized windows vs. a queue model.
module tb_heaa_err_monitor;

  localparam int WIDTH   = 32;
  localparam int SAMPLES = 4;
  localparam int ACC_W   = 34;
  localparam int CNT_W   = $clog2(SAMPLES + 1);
  localparam int ACC_W1  = 48;
  localparam int CNT_W1  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, abort = 1'b0, busy;
  logic start1 = 1'b0, abort1 = 1'b0, busy1;

  int n_checks = 0;
  int n_fail   = 0;
  longint unsigned ed_q[$];

  always #5 clk = ~clk;

  heaa_err_monitor_if #(.WIDTH(WIDTH), .ACC_W(ACC_W),  .CNT_W(CNT_W))  bi ();
  heaa_err_monitor_if #(.WIDTH(WIDTH), .ACC_W(ACC_W1), .CNT_W(CNT_W1)) b1 ();

  heaa_err_monitor #(.WIDTH(WIDTH), .SAMPLES(SAMPLES), .ACC_W(ACC_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .bus(bi.slave)
  );

  heaa_err_monitor #(.WIDTH(WIDTH), .SAMPLES(1), .ACC_W(ACC_W1), .CNT_W(CNT_W1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .busy(busy1), .bus(b1.slave)
  );

  // Reference: ED is the plain distance between the true sum and the adder's answer.
  function automatic longint unsigned ref_ed(input longint unsigned a, b, ap);
    longint unsigned ex = a + b;
    return (ex >= ap) ? ex - ap : ap - ex;
  endfunction

  task automatic ref_window(input int acc_w, output longint unsigned c, s, m);
    longint unsigned cap = (longint'(1) << acc_w) - 1;
    c = 0; s = 0; m = 0;
    foreach (ed_q[i]) begin
      if (ed_q[i] != 0) c++;
      s = s + ed_q[i];
      if (s > cap) s = cap;
      if (ed_q[i] > m) m = ed_q[i];
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ed_q.delete();
  endtask

  task automatic send(input logic [WIDTH-1:0] a, b, input logic [WIDTH:0] ap);
    int n = 0;
    bi.in_a = a; bi.in_b = b; bi.in_approx = ap; bi.in_valid = 1'b1;
    while (bi.in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (bi.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b required 1", bi.in_ready);
    end else begin
      ed_q.push_back(ref_ed(a, b, ap));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bi.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rpt(input string tag);
    int n = 0;
    while (bi.rpt_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_checks++;
    if (bi.rpt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_rpt_timeout: rpt_valid=%b required 1", tag, bi.rpt_valid);
    end
  endtask

  task automatic accept_rpt();
    bi.rpt_ready = 1'b1;
    @(negedge clk);
    bi.rpt_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, bi.in_ready, bi.rpt_valid, busy1, b1.in_ready, b1.rpt_valid} !== 6'b0 ||
        bi.rpt_err_count !== '0 || bi.rpt_ed_sum !== '0 || bi.rpt_ed_max !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b in_ready=%b rpt_valid=%b cnt=%0d sum=%0d max=%0d required all 0",
               busy, bi.in_ready, bi.rpt_valid, bi.rpt_err_count, bi.rpt_ed_sum, bi.rpt_ed_max);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bi.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b in_ready=%b required 0 0", busy, bi.in_ready);
    end
  endtask

  task automatic test_basic();
    pulse_start();
    send(32'd1, 32'd1, 33'd1);
    send(32'd3, 32'd0, 33'd3);
    send(32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000);
    send(32'd5, 32'd5, 33'd0);
    bi.in_valid = 1'b0;
    n_checks++;
    if (bi.rpt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency_early: rpt_valid=%b required 0", bi.rpt_valid);
    end
    @(negedge clk);
    n_checks += 4;
    if (bi.rpt_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_latency: rpt_valid=%b required 1", bi.rpt_valid);
    end
    if (bi.rpt_err_count !== CNT_W'(2)) begin
      n_fail++; $display("FAIL basic_count: got %0d required 2", bi.rpt_err_count);
    end
    if (bi.rpt_ed_sum !== ACC_W'(11)) begin
      n_fail++; $display("FAIL basic_sum: got %0d required 11", bi.rpt_ed_sum);
    end
    if (bi.rpt_ed_max !== 33'd10) begin
      n_fail++; $display("FAIL basic_max: got %0d required 10", bi.rpt_ed_max);
    end
    accept_rpt();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: busy=%b required 0", busy);
    end
  endtask

  task automatic test_gaps();
    pulse_start();
    send(32'd0, 32'd0, 33'd7);
    idle(3);
    send(32'd2, 32'd2, 33'd4);
    idle(2);
    n_checks++;
    if (busy !== 1'b1 || bi.rpt_valid !== 1'b0) begin
      n_fail++; $display("FAIL gaps_midwindow: busy=%b rpt_valid=%b required 1 0", busy, bi.rpt_valid);
    end
    send(32'd10, 32'd20, 33'd30);
    idle(1);
    send(32'd100, 32'd0, 33'd100);
    idle(0);
    wait_rpt("gaps");
    n_checks += 3;
    if (bi.rpt_err_count !== CNT_W'(1)) begin
      n_fail++; $display("FAIL gaps_count: got %0d required 1", bi.rpt_err_count);
    end
    if (bi.rpt_ed_sum !== ACC_W'(7)) begin
      n_fail++; $display("FAIL gaps_sum: got %0d required 7", bi.rpt_ed_sum);
    end
    if (bi.rpt_ed_max !== 33'd7) begin
      n_fail++; $display("FAIL gaps_max: got %0d required 7", bi.rpt_ed_max);
    end
    accept_rpt();
  endtask

  task automatic test_backpressure();
    longint unsigned c, s, m;
    pulse_start();
    for (int i = 0; i < SAMPLES; i++) send($urandom, $urandom, {1'($urandom_range(0, 1)), $urandom});
    idle(0);
    wait_rpt("bp");
    ref_window(ACC_W, c, s, m);
    for (int i = 0; i < 5; i++) begin
      start = (i == 0);
      bi.in_valid = 1'b1;
      bi.in_a = $urandom; bi.in_b = $urandom;
      @(negedge clk);
      n_checks++;
      if (bi.rpt_valid !== 1'b1 || bi.in_ready !== 1'b0 || busy !== 1'b1 ||
          bi.rpt_err_count !== CNT_W'(c) || bi.rpt_ed_sum !== ACC_W'(s) || bi.rpt_ed_max !== 33'(m)) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b busy=%b cnt=%0d sum=%0d max=%0d required 1 0 1 %0d %0d %0d",
                 i, bi.rpt_valid, bi.in_ready, busy, bi.rpt_err_count, bi.rpt_ed_sum, bi.rpt_ed_max, c, s, m);
      end
    end
    start = 1'b0;
    bi.in_valid = 1'b0;
    accept_rpt();
    n_checks++;
    if (busy !== 1'b0 || bi.rpt_valid !== 1'b0 || bi.rpt_ed_sum !== ACC_W'(s)) begin
      n_fail++;
      $display("FAIL bp_release: busy=%b rpt_valid=%b sum=%0d required 0 0 %0d", busy, bi.rpt_valid, bi.rpt_ed_sum, s);
    end
  endtask

  task automatic test_abort();
    pulse_start();
    send(32'd1, 32'd1, 33'd0);
    send(32'd2, 32'd2, 33'd0);
    bi.in_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || bi.rpt_valid !== 1'b0 || bi.rpt_err_count !== CNT_W'(1) ||
        bi.rpt_ed_sum !== ACC_W'(2) || bi.rpt_ed_max !== 33'd2) begin
      n_fail++;
      $display("FAIL abort_idle: busy=%b rpt_valid=%b cnt=%0d sum=%0d max=%0d required 0 0 1 2 2",
               busy, bi.rpt_valid, bi.rpt_err_count, bi.rpt_ed_sum, bi.rpt_ed_max);
    end
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (bi.rpt_valid !== 1'b0) begin
        n_fail++; $display("FAIL abort_no_report: rpt_valid=%b required 0", bi.rpt_valid);
      end
    end
    pulse_start();
    for (int i = 0; i < SAMPLES; i++) begin
      logic [WIDTH-1:0] a = $urandom;
      logic [WIDTH-1:0] b = $urandom;
      send(a, b, {1'b0, a} + {1'b0, b});
    end
    idle(0);
    wait_rpt("abort_rerun");
    n_checks++;
    if (bi.rpt_err_count !== '0 || bi.rpt_ed_sum !== '0 || bi.rpt_ed_max !== '0) begin
      n_fail++;
      $display("FAIL abort_rerun: cnt=%0d sum=%0d max=%0d required 0 0 0", bi.rpt_err_count, bi.rpt_ed_sum, bi.rpt_ed_max);
    end
    accept_rpt();
  endtask

  task automatic test_saturation();
    longint unsigned c, s, m;
    pulse_start();
    repeat (SAMPLES) send(32'd0, 32'd0, 33'h1_FFFF_FFFF);
    idle(0);
    wait_rpt("sat");
    ref_window(ACC_W, c, s, m);
    n_checks += 3;
    if (bi.rpt_ed_sum !== 34'h3_FFFF_FFFF || bi.rpt_ed_sum !== ACC_W'(s)) begin
      n_fail++; $display("FAIL sat_sum: got %0h required 3ffffffff", bi.rpt_ed_sum);
    end
    if (bi.rpt_ed_max !== 33'h1_FFFF_FFFF) begin
      n_fail++; $display("FAIL sat_max: got %0h required 1ffffffff", bi.rpt_ed_max);
    end
    if (bi.rpt_err_count !== CNT_W'(4)) begin
      n_fail++; $display("FAIL sat_count: got %0d required 4", bi.rpt_err_count);
    end
    accept_rpt();
  endtask

  task automatic test_random();
    longint unsigned c, s, m, ex;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0] ap;
    for (int w = 0; w < 6; w++) begin
      pulse_start();
      for (int i = 0; i < SAMPLES; i++) begin
        a = $urandom; b = $urandom;
        ex = longint'(a) + longint'(b);
        case ($urandom_range(0, 3))
          0:       ap = 33'(ex);
          1:       ap = 33'(ex + longint'($urandom_range(1, 255)));
          2:       ap = 33'(ex - longint'($urandom_range(1, 255)));
          default: ap = {1'($urandom_range(0, 1)), $urandom};
        endcase
        send(a, b, ap);
        idle($urandom_range(0, 2));
      end
      wait_rpt("rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ref_window(ACC_W, c, s, m);
      n_checks += 3;
      if (bi.rpt_err_count !== CNT_W'(c)) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d required %0d", w, bi.rpt_err_count, c);
      end
      if (bi.rpt_ed_sum !== ACC_W'(s)) begin
        n_fail++; $display("FAIL rand%0d_sum: got %0d required %0d", w, bi.rpt_ed_sum, s);
      end
      if (bi.rpt_ed_max !== 33'(m)) begin
        n_fail++; $display("FAIL rand%0d_max: got %0d required %0d", w, bi.rpt_ed_max, m);
      end
      accept_rpt();
    end
  endtask

  task automatic test_single_sample();
    int n = 0;
    longint unsigned e;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    b1.in_a = $urandom; b1.in_b = $urandom; b1.in_approx = {1'b0, $urandom};
    e = ref_ed(b1.in_a, b1.in_b, b1.in_approx);
    b1.in_valid = 1'b1;
    while (b1.in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    b1.in_valid = 1'b0;
    n_checks++;
    if (b1.rpt_valid !== 1'b0 || b1.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL single_early: rpt_valid=%b in_ready=%b required 0 0", b1.rpt_valid, b1.in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (b1.rpt_valid !== 1'b1 || busy1 !== 1'b1 || b1.rpt_err_count !== 1'(e != 0) ||
        b1.rpt_ed_sum !== ACC_W1'(e) || b1.rpt_ed_max !== 33'(e)) begin
      n_fail++;
      $display("FAIL single_report: valid=%b cnt=%0d sum=%0d max=%0d required 1 %0d %0d %0d",
               b1.rpt_valid, b1.rpt_err_count, b1.rpt_ed_sum, b1.rpt_ed_max, e != 0, e, e);
    end
    b1.rpt_ready = 1'b1;
    @(negedge clk);
    b1.rpt_ready = 1'b0;
    n_checks++;
    if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL single_done: busy=%b required 0", busy1);
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    send(32'd7, 32'd0, 33'd0);
    send(32'd1, 32'd1, 33'd9);
    bi.in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || bi.in_ready !== 1'b0 || bi.rpt_valid !== 1'b0 ||
        bi.rpt_err_count !== '0 || bi.rpt_ed_sum !== '0 || bi.rpt_ed_max !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b in_ready=%b rpt_valid=%b cnt=%0d sum=%0d max=%0d required all 0",
               busy, bi.in_ready, bi.rpt_valid, bi.rpt_err_count, bi.rpt_ed_sum, bi.rpt_ed_max);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bi.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL async_release_idle: busy=%b in_ready=%b required 0 0", busy, bi.in_ready);
    end
    bi.in_valid = 1'b0;
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || bi.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_restart: busy=%b in_ready=%b required 1 1", busy, bi.in_ready);
    end
  endtask

  initial begin
    bi.in_valid = 1'b0; bi.in_a = '0; bi.in_b = '0; bi.in_approx = '0; bi.rpt_ready = 1'b0;
    b1.in_valid = 1'b0; b1.in_a = '0; b1.in_b = '0; b1.in_approx = '0; b1.rpt_ready = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_abort();
    test_saturation();
    test_random();
    test_single_sample();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
